// File: rtl/controller_pkg.sv
// Shared definitions for the ENTDAA initiator: FSM state encoding, the
// broadcast-read byte used to solicit targets, and the provisional ID length.
package controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ISSUE_RSTART,
        ST_SEND_RSVD,
        ST_RX_RSVD_ACK,
        ST_READ_ID_BIT,
        ST_WAIT_ADDR,
        ST_SEND_ADDR,
        ST_RX_ADDR_ACK,
        ST_ISSUE_STOP,
        ST_DONE
    } state_e;

    // 7'h7E with RnW = 1
    localparam logic [7:0] RSVD_BYTE = 8'hFD;
    localparam int         ID_LEN    = 64;

    // Address byte as sent on the bus: the parity bit makes the total number of ones odd.
    function automatic logic [7:0] addr_with_parity(input logic [6:0] addr);
        return {addr, ~(^addr)};
    endfunction

endpackage

// File: rtl/entdaa_initiator.sv
// ENTDAA round sequencer: repeatedly solicits targets with Sr + 7E/R, reads the
// 64-bit provisional ID, hands out a dynamic address and reports each assignment.
module entdaa_initiator
    import controller_pkg::*;
#(
    parameter int MaxDevices = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [6:0]  next_addr_i,
    input  logic        next_addr_valid_i,
    output logic        bus_tx_req_byte_o,
    output logic        bus_tx_req_bit_o,
    output logic [7:0]  bus_tx_req_value_o,
    input  logic        bus_tx_done_i,
    output logic        bus_tx_sel_od_pp_o,
    output logic        bus_rx_req_byte_o,
    output logic        bus_rx_req_bit_o,
    input  logic [7:0]  bus_rx_data_i,
    input  logic        bus_rx_done_i,
    output logic        bus_rstart_req_o,
    output logic        bus_stop_req_o,
    input  logic        bus_cond_done_i,
    output logic [47:0] pid_o,
    output logic [7:0]  bcr_o,
    output logic [7:0]  dcr_o,
    output logic [6:0]  assigned_addr_o,
    output logic        record_valid_o,
    output logic [3:0]  dev_count_o,
    output logic        done_o,
    output logic        no_more_dev_o,
    output logic        error_o
);

    localparam logic [3:0] MAX_CNT = 4'(MaxDevices);
    localparam logic [6:0] ID_CNT  = 7'(ID_LEN);

    state_e              state_q, state_d;
    logic [ID_LEN-1:0]   shift_q;
    logic [6:0]          bit_cnt_q;
    logic [6:0]          addr_q;
    logic [3:0]          dev_count_q;
    logic                no_more_q;
    logic                error_q;
    logic [47:0]         pid_q;
    logic [7:0]          bcr_q;
    logic [7:0]          dcr_q;
    logic [6:0]          assigned_q;
    logic                record_valid_q;
    logic                abort_hit;
    logic                tx_byte;
    logic [7:0]          tx_value;
    logic                rx_bit;
    logic                rstart_req;
    logic                stop_req;
    logic                unused_rx_bits;

    // Only single-bit reads are issued, so the upper RX bits carry nothing.
    assign unused_rx_bits = ^bus_rx_data_i[7:1];

    assign abort_hit = abort_i && !(state_q inside {ST_IDLE, ST_ISSUE_STOP, ST_DONE});

    always_comb begin
        state_d    = state_q;
        tx_byte    = 1'b0;
        tx_value   = 8'h00;
        rx_bit     = 1'b0;
        rstart_req = 1'b0;
        stop_req   = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_ISSUE_RSTART;
            ST_ISSUE_RSTART: begin
                rstart_req = 1'b1;
                if (bus_cond_done_i) state_d = ST_SEND_RSVD;
            end
            ST_SEND_RSVD: begin
                tx_byte  = 1'b1;
                tx_value = RSVD_BYTE;
                if (bus_tx_done_i) state_d = ST_RX_RSVD_ACK;
            end
            ST_RX_RSVD_ACK: begin
                rx_bit = 1'b1;
                if (bus_rx_done_i) state_d = bus_rx_data_i[0] ? ST_ISSUE_STOP : ST_READ_ID_BIT;
            end
            ST_READ_ID_BIT: begin
                rx_bit = 1'b1;
                if (bus_rx_done_i && bit_cnt_q == 7'd1) state_d = ST_WAIT_ADDR;
            end
            ST_WAIT_ADDR: if (next_addr_valid_i) state_d = ST_SEND_ADDR;
            ST_SEND_ADDR: begin
                tx_byte  = 1'b1;
                tx_value = addr_with_parity(addr_q);
                if (bus_tx_done_i) state_d = ST_RX_ADDR_ACK;
            end
            ST_RX_ADDR_ACK: begin
                rx_bit = 1'b1;
                if (bus_rx_done_i) begin
                    if (bus_rx_data_i[0] || (dev_count_q + 4'd1 == MAX_CNT)) state_d = ST_ISSUE_STOP;
                    else state_d = ST_ISSUE_RSTART;
                end
            end
            ST_ISSUE_STOP: begin
                stop_req = 1'b1;
                if (bus_cond_done_i) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any completion seen this cycle and withdraws the request.
        if (abort_hit) begin
            state_d    = ST_ISSUE_STOP;
            tx_byte    = 1'b0;
            tx_value   = 8'h00;
            rx_bit     = 1'b0;
            rstart_req = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            addr_q         <= '0;
            dev_count_q    <= '0;
            no_more_q      <= 1'b0;
            error_q        <= 1'b0;
            pid_q          <= '0;
            bcr_q          <= '0;
            dcr_q          <= '0;
            assigned_q     <= '0;
            record_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            record_valid_q <= 1'b0;
            if (abort_hit) begin
                error_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (start_i) begin
                        dev_count_q <= '0;
                        no_more_q   <= 1'b0;
                        error_q     <= 1'b0;
                    end
                    ST_RX_RSVD_ACK: if (bus_rx_done_i) begin
                        if (bus_rx_data_i[0]) begin
                            no_more_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= ID_CNT;
                            shift_q   <= '0;
                        end
                    end
                    ST_READ_ID_BIT: if (bus_rx_done_i) begin
                        shift_q   <= {shift_q[ID_LEN-2:0], bus_rx_data_i[0]};
                        bit_cnt_q <= bit_cnt_q - 7'd1;
                    end
                    ST_WAIT_ADDR: if (next_addr_valid_i) addr_q <= next_addr_i;
                    ST_RX_ADDR_ACK: if (bus_rx_done_i) begin
                        if (bus_rx_data_i[0]) begin
                            error_q <= 1'b1;
                        end else begin
                            pid_q          <= shift_q[63:16];
                            bcr_q          <= shift_q[15:8];
                            dcr_q          <= shift_q[7:0];
                            assigned_q     <= addr_q;
                            record_valid_q <= 1'b1;
                            dev_count_q    <= dev_count_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus_tx_req_byte_o  = tx_byte;
    assign bus_tx_req_bit_o   = 1'b0;
    assign bus_tx_req_value_o = tx_value;
    assign bus_tx_sel_od_pp_o = 1'b0;
    assign bus_rx_req_byte_o  = 1'b0;
    assign bus_rx_req_bit_o   = rx_bit;
    assign bus_rstart_req_o   = rstart_req;
    assign bus_stop_req_o     = stop_req;
    assign pid_o              = pid_q;
    assign bcr_o              = bcr_q;
    assign dcr_o              = dcr_q;
    assign assigned_addr_o    = assigned_q;
    assign record_valid_o     = record_valid_q;
    assign dev_count_o        = dev_count_q;
    assign done_o             = (state_q == ST_DONE);
    assign no_more_dev_o      = no_more_q;
    assign error_o            = error_q;

endmodule
